sys_mem_arbiter: RTL
====================

# sys_mem_arbiter

Parametrised RAM-port arbiter sitting between NREQ processor-side memory requesters (cores/caches) and the single system RAM, with a testbench override path. It replaces the fixed two-way testbench/CPU mux with:
- a registered round-robin grant state machine,
- per-requester ready handshakes,
- write-over-read resolution,
- clean abort and override handling.

## Interface
Parameters:
- NREQ, 2, number of processor-side requesters (≥1)
- AW, 32, address width
- DW, 32, data width

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- nRST  in  1  reset, synchronous, active-low
- tbCTRL  in  1  testbench owns RAM when high
- tb_ren, tb_wen  in  1 each  testbench read/write strobes
- tb_addr  in  AW  testbench address
- tb_store  in  DW  testbench write data
- req_ren, req_wen  in  NREQ each  per-requester read/write strobes, bit i = requester i
- req_addr  in  NREQ*AW  packed addresses, slice i = [i*AW +: AW]
- req_store  in  NREQ*DW  packed write data, same packing
- req_ready  out  NREQ  one-hot completion pulse to the granted requester
- req_load  out  DW  read data, broadcast to all requesters
- ram_ren, ram_wen  out  1 each  RAM strobes
- ram_addr  out  AW  RAM address
- ram_store  out  DW  RAM write data
- ram_load  in  DW  RAM read data
- ram_ready  in  1  RAM access complete this cycle

## Operation
- State: two-state FSM.
  - IDLE: no requester granted.
  - BUSY: granted requester index `gnt`, width clog2(NREQ), min 1.
  - Round-robin pointer `ptr`, same width.
- Request: requester i requests when req_ren[i] | req_wen[i].
- IDLE, tbCTRL=0:
  - Search indices ptr, ptr+1, …, wrapping modulo NREQ.
  - First requesting index is latched into `gnt`; FSM goes to BUSY.
  - No requests: stay in IDLE.
- BUSY:
  - RAM outputs driven from slice `gnt`.
  - ram_wen = req_wen[gnt].
  - ram_ren = req_ren[gnt] & ~req_wen[gnt]; write wins if both strobes are high.
- Completion (BUSY and ram_ready=1):
  - req_ready[gnt]=1 in the same cycle.
  - Next edge: ptr ← (gnt+1) mod NREQ; FSM → IDLE.
- Abort (BUSY, granted requester drops both strobes, ram_ready=0):
  - Next edge: FSM → IDLE, ptr ← (gnt+1) mod NREQ.
  - No req_ready is generated.
- Testbench override (tbCTRL=1, any state):
  - RAM outputs are taken combinationally from tb_*, with tb_wen also winning over tb_ren.
  - All req_ready = 0.
  - From BUSY, next edge goes to IDLE with ptr unchanged; the abandoned requester re-arbitrates normally.
  - No arbitration occurs while tbCTRL=1.
- Outputs in IDLE with tbCTRL=0: ram_ren=ram_wen=0, ram_addr=0, ram_store=0, req_ready=0.
- req_load = ram_load at all times; it is only meaningful with req_ready.
- NREQ=1: ptr is constant 0. Behaviour is otherwise identical.

## Timing
- Reset (nRST low at an edge):
  - FSM=IDLE, gnt=0, ptr=0.
  - Consequently ram_ren=ram_wen=0, ram_addr=0, ram_store=0, req_ready=0 from that edge onward.
  - Reset mid-BUSY abandons the access; no req_ready is issued.
- Arbitration latency: a request visible at edge k is granted at edge k. RAM strobes for it appear in the cycle after edge k.
- Minimum access: 2 cycles (1 arbitration + 1 RAM cycle with ram_ready=1).
- Back-to-back: after a completion there is 1 idle cycle before the next grant's strobes.
- Requesters hold their strobes, address and data stable from assertion until req_ready. Changing addr/data mid-BUSY propagates straight to the RAM (not latched).
- ram_ready is ignored in IDLE and whenever tbCTRL=1.
- Fairness: a continuously requesting requester is served within NREQ grants.

## Test plan
- Reset: assert nRST=0 with req_ren=2'b11 → ram_ren=0, req_ready=0. Release → first grant to requester 0 (ptr=0).
- Round-robin, NREQ=2:
  - Both requesters read continuously; RAM returns ram_ready one cycle after strobe, ram_load=addr.
  - Required: grants alternate 0,1,0,1.
  - Each req_ready is preceded by exactly one ram_ren cycle with the correct slice address (0x100 / 0x200).
- Write priority: requester 1 asserts ren=wen=1, addr=0x40, store=0xDEADBEEF → ram_wen=1, ram_ren=0, ram_store=0xDEADBEEF, then req_ready=2'b10 on ram_ready.
- Abort: requester 0 granted, drops its strobes before ram_ready → no req_ready. Next cycle IDLE; requester 1 (waiting) is granted next.
- Override: tbCTRL=1 during a BUSY access by requester 1, tb_wen=1, tb_addr=0x8 → RAM immediately shows the tb values and req_ready stays 0. After tbCTRL=0, requester 1 is re-granted (ptr still 1).
- Wrap, NREQ=4: only requesters 3 and 0 request, ptr=3 → grant order 3, 0, 3, 0.

Source files
------------

// File: rtl/sys_mem_arbiter.sv
// Round-robin arbiter between NREQ memory requesters and the single system RAM,
// with a testbench override that takes the RAM port combinationally.
//
// state | meaning
// IDLE  | no requester granted; arbitrate from ptr when tbCTRL is low
// BUSY  | requester gnt owns the RAM until ram_ready, abort or override
module sys_mem_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              tbCTRL,
  input  logic              tb_ren,
  input  logic              tb_wen,
  input  logic [AW-1:0]     tb_addr,
  input  logic [DW-1:0]     tb_store,
  input  logic [NREQ-1:0]   req_ren,
  input  logic [NREQ-1:0]   req_wen,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_store,
  output logic [NREQ-1:0]   req_ready,
  output logic [DW-1:0]     req_load,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [AW-1:0]     ram_addr,
  output logic [DW-1:0]     ram_store,
  input  logic [DW-1:0]     ram_load,
  input  logic              ram_ready
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [GW-1:0]   gnt;
  logic [GW-1:0]   ptr;
  logic [GW-1:0]   sel;
  logic [GW-1:0]   gnt_next;
  logic            found;
  logic [NREQ-1:0] req_any;

  assign req_any  = req_ren | req_wen;
  assign gnt_next = (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
  assign req_load = ram_load;

  // Walk downward so the index closest to ptr is the one left in sel.
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req_any[idx]) begin
        found = 1'b1;
        sel   = GW'(idx);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
    end else if (tbCTRL) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt   <= sel;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (ram_ready || !req_any[gnt]) begin
            ptr   <= gnt_next;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    req_ready = '0;
    if (tbCTRL) begin
      ram_wen   = tb_wen;
      ram_ren   = tb_ren & ~tb_wen;
      ram_addr  = tb_addr;
      ram_store = tb_store;
    end else if (state == BUSY) begin
      ram_wen   = req_wen[gnt];
      ram_ren   = req_ren[gnt] & ~req_wen[gnt];
      ram_addr  = req_addr[int'(gnt)*AW +: AW];
      ram_store = req_store[int'(gnt)*DW +: DW];
      if (ram_ready) req_ready[gnt] = 1'b1;
    end
  end

endmodule
